mem_responder: RTL and testbench

//  Memory-side responder for the SLC-3 datapath. Services the control unit's Mem_OE / Mem_WE

---
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus between the SLC-3 control unit (master) and the memory responder (slave).
// Defining MEM_RESP_ERR_EN adds the sticky Mem_Err flag.
interface mem_responder_if;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic [15:0] HEX_Data;
`ifdef MEM_RESP_ERR_EN
    logic        Mem_Err;

    modport master (
        output ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        input  Data_to_CPU, Mem_Ready, HEX_Data, Mem_Err
    );
    modport slave (
        input  ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        output Data_to_CPU, Mem_Ready, HEX_Data, Mem_Err
    );
`else
    modport master (
        output ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        input  Data_to_CPU, Mem_Ready, HEX_Data
    );
    modport slave (
        input  ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        output Data_to_CPU, Mem_Ready, HEX_Data
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 datapath: on-chip word RAM plus one memory-mapped I/O word.
// Optional feature macro MEM_RESP_ERR_EN adds a sticky Mem_Err flag (unmapped access or OE&WE together).
module mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic [15:0]   addr_q, wdata_q, rd_q, hex_q, rd_data;
    logic          ready_q;
    logic          accept_rd, accept_wr, load_rd, commit_wr;
    logic          wait_done, addr_is_io, addr_mapped;
    logic [15:0]   ram [DEPTH];

    assign wait_done   = (wait_cnt == CW'(WAIT_STATES));
    assign addr_is_io  = (addr_q == IO_ADDR);
    assign addr_mapped = (32'(addr_q) < DEPTH);

    // IO word takes precedence over RAM; unmapped reads return zero
    assign rd_data = addr_is_io  ? bus.Switches :
                     addr_mapped ? ram[addr_q[AW-1:0]] : 16'h0000;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept_rd     = 1'b0;
        accept_wr     = 1'b0;
        load_rd       = 1'b0;
        commit_wr     = 1'b0;
        case (state)
            IDLE: begin
                wait_cnt_next = '0;
                if (bus.Mem_WE) begin
                    accept_wr  = 1'b1;
                    state_next = WR_WAIT;
                end else if (bus.Mem_OE) begin
                    accept_rd  = 1'b1;
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!bus.Mem_OE) begin
                    state_next = IDLE;
                end else if (wait_done) begin
                    load_rd    = 1'b1;
                    state_next = RD_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            RD_DONE: if (!bus.Mem_OE) state_next = IDLE;
            WR_WAIT: begin
                if (!bus.Mem_WE) begin
                    state_next = IDLE;
                end else if (wait_done) begin
                    commit_wr  = 1'b1;
                    state_next = WR_DONE;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            WR_DONE: if (!bus.Mem_WE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rd_q     <= '0;
            hex_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ready_q  <= (state_next == RD_DONE) || (state_next == WR_DONE);
            if (load_rd)                rd_q  <= rd_data;
            if (commit_wr && addr_is_io) hex_q <= wdata_q;
        end
    end

    // Access operands are captured once so later bus changes cannot disturb the access
    always_ff @(posedge Clk) begin
        if (accept_rd || accept_wr) addr_q  <= bus.ADDR;
        if (accept_wr)              wdata_q <= bus.Data_from_CPU;
    end

    always_ff @(posedge Clk) begin
        if (!Reset && commit_wr && !addr_is_io && addr_mapped)
            ram[addr_q[AW-1:0]] <= wdata_q;
    end

    assign bus.Data_to_CPU = rd_q;
    assign bus.Mem_Ready   = ready_q;
    assign bus.HEX_Data    = hex_q;

`ifdef MEM_RESP_ERR_EN
    logic err_q;
    logic start_unmapped;

    assign start_unmapped = (bus.ADDR != IO_ADDR) && (32'(bus.ADDR) >= DEPTH);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if ((accept_rd || accept_wr) && (start_unmapped || (bus.Mem_OE && bus.Mem_WE))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.Mem_Err = err_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (WAIT_STATES 0 and 2) driven with identical stimulus.
module tb_mem_responder;
    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic [15:0] addr, wdata, sw;
    logic        oe, we;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    assign bus0.ADDR = addr;  assign bus0.Data_from_CPU = wdata;
    assign bus0.Mem_OE = oe;  assign bus0.Mem_WE = we;  assign bus0.Switches = sw;
    assign bus1.ADDR = addr;  assign bus1.Data_from_CPU = wdata;
    assign bus1.Mem_OE = oe;  assign bus1.Mem_WE = we;  assign bus1.Switches = sw;

    mem_responder #(.DEPTH(1024), .WAIT_STATES(W0), .IO_ADDR(16'hFFFF)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0.slave));
    mem_responder #(.DEPTH(1024), .WAIT_STATES(W1), .IO_ADDR(16'hFFFF)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model and scoreboard
    logic [15:0] mem_model [int];
    logic [15:0] hex_m;
    logic [15:0] last_rd [2];
    logic [15:0] rdq0 [$];
    logic [15:0] rdq1 [$];
    int          cyc = 0;
    int          start_cyc = 0;
    bit          op_rd = 1'b0;
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a == 16'hFFFF) return sw;
        if (32'(a) >= 1024) return 16'h0000;
        return mem_model.exists(int'(a)) ? mem_model[int'(a)] : 16'hxxxx;
    endfunction

    task automatic on_ready(input int idx, input logic [15:0] data);
        logic [15:0] exp;
        int unsigned w;
        w = (idx == 0) ? W0 : W1;
        check($sformatf("latency%0d", idx), 16'(cyc - start_cyc), 16'(1 + w));
        if (op_rd) begin
            check($sformatf("rdq%0d_pending", idx), 16'((idx == 0) ? rdq0.size() : rdq1.size()), 16'd1);
            if (idx == 0 && rdq0.size() > 0) begin
                exp = rdq0.pop_front();
                check("rd_data0", data, exp);
                last_rd[0] = exp;
            end else if (idx == 1 && rdq1.size() > 0) begin
                exp = rdq1.pop_front();
                check("rd_data1", data, exp);
                last_rd[1] = exp;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus0.Mem_Ready && !prev0) on_ready(0, bus0.Data_to_CPU);
            if (bus1.Mem_Ready && !prev1) on_ready(1, bus1.Data_to_CPU);
        end
        prev0 = bus0.Mem_Ready;
        prev1 = bus1.Mem_Ready;
    end

    // One strobe assertion; d_late replaces the write data after the first sampled edge
    task automatic access(input bit is_wr, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] d_late, input int hold);
        @(negedge Clk);
        addr = a;
        wdata = d;
        op_rd = !is_wr;
        start_cyc = cyc + 1;
        we = is_wr;
        oe = !is_wr || both;
        if (!is_wr) begin
            if (hold >= int'(2 + W0)) rdq0.push_back(model_read(a));
            if (hold >= int'(2 + W1)) rdq1.push_back(model_read(a));
        end
        @(negedge Clk);
        wdata = d_late;
        addr = 16'h0ABC;
        repeat (hold - 1) @(negedge Clk);
        oe = 1'b0;
        we = 1'b0;
        if (is_wr && hold >= int'(2 + W1)) begin
            if (a == 16'hFFFF) hex_m = d;
            else if (32'(a) < 1024) mem_model[int'(a)] = d;
        end
        repeat (2) @(negedge Clk);
        check("ready0_idle", 16'(bus0.Mem_Ready), 16'd0);
        check("ready1_idle", 16'(bus1.Mem_Ready), 16'd0);
        check("rdq0_drained", 16'(rdq0.size()), 16'd0);
        check("rdq1_drained", 16'(rdq1.size()), 16'd0);
        check("hold_rd0", bus0.Data_to_CPU, last_rd[0]);
        check("hold_rd1", bus1.Data_to_CPU, last_rd[1]);
        check("hex0", bus0.HEX_Data, hex_m);
        check("hex1", bus1.HEX_Data, hex_m);
        rdq0.delete();
        rdq1.delete();
    endtask

    task automatic check_reset_state();
        check("rst_data0", bus0.Data_to_CPU, 16'h0000);
        check("rst_data1", bus1.Data_to_CPU, 16'h0000);
        check("rst_ready0", 16'(bus0.Mem_Ready), 16'd0);
        check("rst_ready1", 16'(bus1.Mem_Ready), 16'd0);
        check("rst_hex0", bus0.HEX_Data, 16'h0000);
        check("rst_hex1", bus1.HEX_Data, 16'h0000);
`ifdef MEM_RESP_ERR_EN
        check("rst_err0", 16'(bus0.Mem_Err), 16'd0);
        check("rst_err1", 16'(bus1.Mem_Err), 16'd0);
`endif
    endtask

    task automatic check_err(input logic exp);
`ifdef MEM_RESP_ERR_EN
        check("err0", 16'(bus0.Mem_Err), 16'(exp));
        check("err1", 16'(bus1.Mem_Err), 16'(exp));
`else
        if (exp === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        logic [15:0] a;
        Reset = 1'b1;
        oe = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        sw = 16'h0000;
        hex_m = 16'h0000;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check_reset_state();

        // Basic write then read back
        access(1'b1, 1'b0, 16'h0010, 16'h1234, 16'h1234, 6);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 5);

        // I/O word: HEX display write, switch read
        access(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 16'hBEEF, 6);
        sw = 16'h00A5;
        access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 5);

        // Long write with data changing mid-access: latched value committed once
        access(1'b1, 1'b0, 16'h0020, 16'h0001, 16'h0002, 6);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 5);

        // Read aborted before completion: no ready, Data_to_CPU unchanged
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1);

        // Reset during a pending write discards it
        access(1'b1, 1'b0, 16'h0030, 16'h1111, 16'h1111, 6);
        @(negedge Clk);
        addr = 16'h0030;
        wdata = 16'h5555;
        op_rd = 1'b0;
        start_cyc = cyc + 1;
        we = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        we = 1'b0;
        hex_m = 16'h0000;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        check_reset_state();
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 5);

        // Unmapped accesses: read zero, write dropped
        access(1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 5);
        check_err(1'b1);
        access(1'b1, 1'b0, 16'h8000, 16'hDEAD, 16'hDEAD, 6);
        access(1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 5);
        access(1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h0000, 1);

        // OE and WE together: write wins
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        hex_m = 16'h0000;
        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        check_err(1'b0);
        access(1'b1, 1'b1, 16'h0040, 16'h7777, 16'h7777, 6);
        check_err(1'b1);
        access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 5);

        // Randomised traffic over a small address pool, plus last RAM word
        access(1'b1, 1'b0, 16'h03FF, 16'hA5A5, 16'hA5A5, 6);
        access(1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h0000, 5);
        for (int i = 0; i < 16; i++) begin
            a = 16'h0100 + 16'($urandom_range(0, 7));
            if (mem_model.exists(int'(a)) && ($urandom_range(0, 1) == 1))
                access(1'b0, 1'b0, a, 16'h0000, 16'h0000, 5);
            else
                access(1'b1, 1'b0, a, 16'($urandom), 16'($urandom), 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
